// File: rtl/moving_average_sample_source_if.sv
// Sample stream between the stimulus source and the moving-average filter input.
// The source drives data/valid; the sink drives ready.
interface moving_average_sample_source_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output out_data,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/moving_average_sample_source.sv
// Deterministic burst stimulus source for the moving-average filter input.
// Generates `length` signed samples (ramp / constant / LFSR / alternating sign)
// over a valid/ready stream, then pulses done for one cycle.
// Optional build macro SAMPLE_SOURCE_ABORT_EN adds an abort input that ends
// the burst after the next transfer.
module moving_average_sample_source #(
  parameter int          DATA_W    = 8,
  parameter int          COUNT_W   = 16,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic               system1000,
  input  logic               system1000_rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [COUNT_W-1:0] length,
  input  logic [DATA_W-1:0]  const_val,
`ifdef SAMPLE_SOURCE_ABORT_EN
  input  logic               abort,
`endif
  moving_average_sample_source_if.master out_if,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] sent_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    PAT_RAMP  = 2'd0,
    PAT_CONST = 2'd1,
    PAT_LFSR  = 2'd2,
    PAT_ALT   = 2'd3
  } pattern_t;

  state_t             state_q,  state_d;
  pattern_t           mode_q,   mode_d;
  logic [COUNT_W-1:0] length_q, length_d;
  logic [DATA_W-1:0]  const_q,  const_d;
  logic [15:0]        lfsr_q,   lfsr_d;
  logic               alt_neg_q, alt_neg_d;
  logic [DATA_W-1:0]  data_q,   data_d;
  logic               valid_q,  valid_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [COUNT_W-1:0] sent_q,   sent_d;
`ifdef SAMPLE_SOURCE_ABORT_EN
  logic               abort_q,  abort_d;
`endif

  logic        xfer;
  logic        last_xfer;
  logic [15:0] lfsr_next;

  assign xfer      = valid_q & out_if.out_ready;
  assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  // Burst sequencing and pattern generation; all outputs come straight from flops.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    length_d  = length_q;
    const_d   = const_q;
    lfsr_d    = lfsr_q;
    alt_neg_d = alt_neg_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sent_d    = sent_q;
    last_xfer = 1'b0;
`ifdef SAMPLE_SOURCE_ABORT_EN
    abort_d   = abort_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d    = pattern_t'(mode);
          length_d  = length;
          const_d   = const_val;
          sent_d    = '0;
          lfsr_d    = LFSR_SEED;
          alt_neg_d = 1'b0;
          // Sample 0 is presented in the first RUN cycle, so it is built from
          // the live inputs rather than the latches being loaded now.
          data_d    = (pattern_t'(mode) == PAT_LFSR) ? LFSR_SEED[DATA_W-1:0] : const_val;
          busy_d    = 1'b1;
          if (length == '0) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            valid_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
`ifdef SAMPLE_SOURCE_ABORT_EN
        abort_d = abort_q | abort;
`endif
        if (xfer) begin
          sent_d = sent_q + COUNT_W'(1);
          case (mode_q)
            PAT_RAMP:  data_d = data_q + DATA_W'(1);
            PAT_CONST: data_d = const_q;
            PAT_LFSR: begin
              lfsr_d = lfsr_next;
              data_d = lfsr_next[DATA_W-1:0];
            end
            PAT_ALT: begin
              alt_neg_d = ~alt_neg_q;
              data_d    = alt_neg_q ? const_q : -const_q;
            end
            default: data_d = data_q;
          endcase
          last_xfer = (sent_d == length_q);
`ifdef SAMPLE_SOURCE_ABORT_EN
          last_xfer = last_xfer | abort_q | abort;
`endif
          if (last_xfer) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
`ifdef SAMPLE_SOURCE_ABORT_EN
        abort_d = 1'b0;
`endif
      end

      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge system1000 or posedge system1000_rst) begin
    if (system1000_rst) begin
      state_q   <= ST_IDLE;
      mode_q    <= PAT_RAMP;
      length_q  <= '0;
      const_q   <= '0;
      lfsr_q    <= LFSR_SEED;
      alt_neg_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sent_q    <= '0;
`ifdef SAMPLE_SOURCE_ABORT_EN
      abort_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      length_q  <= length_d;
      const_q   <= const_d;
      lfsr_q    <= lfsr_d;
      alt_neg_q <= alt_neg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sent_q    <= sent_d;
`ifdef SAMPLE_SOURCE_ABORT_EN
      abort_q   <= abort_d;
`endif
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign sent_count       = sent_q;

endmodule

// File: tb/tb_moving_average_sample_source.sv
// Bench for moving_average_sample_source: expected samples are queued when a
// burst is launched and compared against the stream as transfers happen.
module tb_moving_average_sample_source;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [1:0]    mode;
  logic [CW-1:0] length;
  logic [DW-1:0] const_val;
  logic          busy;
  logic          done;
  logic [CW-1:0] sent_count;

  moving_average_sample_source_if #(.DATA_W(DW)) sif ();

  moving_average_sample_source #(
    .DATA_W   (DW),
    .COUNT_W  (CW),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .system1000    (clk),
    .system1000_rst(rst),
    .start         (start),
    .mode          (mode),
    .length        (length),
    .const_val     (const_val),
    .out_if        (sif.master),
    .busy          (busy),
    .done          (done),
    .sent_count    (sent_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned tests_run    = 0;
  int unsigned tests_failed = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference pattern generator, written from the pattern definitions.
  task automatic push_expected(input logic [1:0] m, input int n, input logic [DW-1:0] cv);
    logic [15:0]   lf;
    logic [DW-1:0] s;
    logic [DW-1:0] idx;
    lf = 16'hACE1;
    for (int i = 0; i < n; i++) begin
      idx = DW'(i);
      case (m)
        2'd0: s = cv + idx;
        2'd1: s = cv;
        2'd2: begin
          s  = lf[DW-1:0];
          lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        end
        default: s = (i % 2 == 1) ? (~cv + 8'd1) : cv;
      endcase
      exp_q.push_back(s);
    end
  endtask

  function automatic logic ready_at(input logic [15:0] pat, input int plen, input int c);
    return (c < plen) ? pat[c] : 1'b1;
  endfunction

  // Launch one burst, drive ready from the pattern, check every cycle through done.
  task automatic do_burst(input logic [1:0] m, input int len, input logic [DW-1:0] cv,
                          input logic [15:0] rdy_pat, input int rdy_len);
    int ed;
    int cnt;
    exp_q.delete();
    push_expected(m, len, cv);
    // cycle index (after the start edge) in which done must be high
    ed = 0;
    cnt = 0;
    if (len != 0) begin
      for (int k = 0; k < 200; k++) begin
        if (ready_at(rdy_pat, rdy_len, k)) cnt++;
        if (cnt == len) begin
          ed = k + 1;
          break;
        end
      end
    end
    @(posedge clk); #1;
    start = 1'b1; mode = m; length = CW'(len); const_val = cv;
    @(posedge clk); #1;
    start = 1'b0;
    // later input changes must not affect the burst
    mode = ~m; length = CW'(len + 7); const_val = cv ^ 8'h5A;
    for (int c = 0; c <= ed; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      sif.out_ready = ready_at(rdy_pat, rdy_len, c);
      @(negedge clk);
      if (c < ed) begin
        check_eq("run_valid", sif.out_valid, 1'b1);
        check_eq("run_busy", busy, 1'b1);
        check_eq("run_done", done, 1'b0);
        if (sif.out_valid) begin
          if (exp_q.size() == 0) begin
            check_eq("extra_sample", 32'd1, 32'd0);
          end else begin
            check_eq("sample", sif.out_data, exp_q[0]);
            if (sif.out_ready) void'(exp_q.pop_front());
          end
        end
      end else begin
        check_eq("done_pulse", done, 1'b1);
        check_eq("done_valid", sif.out_valid, 1'b0);
        check_eq("done_busy", busy, 1'b1);
        check_eq("done_count", sent_count, 32'(len));
        check_eq("queue_empty", exp_q.size(), 0);
      end
    end
    @(posedge clk); #1;
    sif.out_ready = 1'b1;
    @(negedge clk);
    check_eq("idle_done", done, 1'b0);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_valid", sif.out_valid, 1'b0);
    check_eq("count_hold", sent_count, 32'(len));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; length = '0; const_val = '0;
    sif.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_valid", sif.out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_count", sent_count, 0);
    check_eq("rst_data", sif.out_data, 0);
    rst = 1'b0;

    // ramp across the signed wrap: 126,127,-128,-127
    do_burst(2'd0, 4, 8'd126, 16'h0000, 0);
    // constant with stalls: ready 1,0,0,1,0,1
    do_burst(2'd1, 3, 8'd5, 16'b101001, 6);
    // zero-length burst
    do_burst(2'd0, 0, 8'd9, 16'h0000, 0);
    // alternating sign, including the -128 wrap
    do_burst(2'd3, 3, 8'h80, 16'h0000, 0);
    do_burst(2'd3, 3, 8'd3, 16'b0110, 4);
    // LFSR, twice for repeatability
    do_burst(2'd2, 3, 8'd0, 16'h0000, 0);
    do_burst(2'd2, 3, 8'd0, 16'b0101, 4);

    // reset in the middle of a burst after 2 transfers
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; length = 16'd10; const_val = 8'd20;
    sif.out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_data0", sif.out_data, 20);
    @(negedge clk);
    check_eq("pre_rst_data1", sif.out_data, 21);
    @(posedge clk); #2;
    check_eq("pre_rst_count", sent_count, 2);
    rst = 1'b1;
    #1;
    check_eq("async_valid", sif.out_valid, 1'b0);
    check_eq("async_busy", busy, 1'b0);
    check_eq("async_count", sent_count, 0);
    check_eq("async_done", done, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    do_burst(2'd0, 3, 8'd50, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
